// File: rtl/tf_provider_pkg.sv
// Shared FFT twiddle definitions: float width, default transform size, {re, im} packing,
// sign-bit location and the helpers that build the half-circle twiddle table.
package tf_provider_pkg;

    localparam int unsigned tf_float_len = 32;
    localparam int unsigned tf_log_n     = 13;
    localparam int unsigned tf_word_len  = 2 * tf_float_len;

    // One complex twiddle; im occupies the low half of the word.
    typedef struct packed {
        logic [tf_float_len-1:0] re;
        logic [tf_float_len-1:0] im;
    } tf_word_t;

    // Number of distinct twiddles (N/2) for a 2^log_n point transform.
    function automatic int unsigned tf_half_n(input int unsigned log_n);
        return 1 << (log_n - 1);
    endfunction

    // Bit index of the sign of an IEEE-754 component of the given width.
    function automatic int unsigned tf_sign_bit(input int unsigned flen);
        return flen - 1;
    endfunction

    // Double to single precision, round-to-nearest-even; magnitudes stay in the normal range
    // for every twiddle, so no denormal or overflow handling is needed.
    function automatic logic [31:0] tf_real_to_f32(input real x);
        logic [63:0] d;
        logic [7:0]  e;
        logic [22:0] f;
        logic        up;
        logic [30:0] mag;
        if (x == 0.0) begin
            return 32'h0000_0000;
        end
        d   = $realtobits(x);
        e   = 8'(d[62:52] - 11'd896);
        f   = d[51:29];
        up  = d[28] & ((|d[27:0]) | d[29]);
        mag = {e, f} + 31'(up);
        return {d[63], mag};
    endfunction

    // Entry m of the table: W_N^m = exp(-j*2*pi*m/N). The second quadrant is folded onto the
    // first so that exact zeros and ones come out exact.
    function automatic tf_word_t tf_twiddle(input int unsigned m, input int unsigned log_n);
        tf_word_t    tw;
        int unsigned quarter;
        real         pi;
        real         th;
        pi      = 3.14159265358979323846;
        quarter = 1 << (log_n - 2);
        if (m < quarter) begin
            th    = 2.0 * pi * real'(m) / real'(1 << log_n);
            tw.re = tf_real_to_f32($cos(th));
            tw.im = tf_real_to_f32(-$sin(th));
        end else begin
            th    = 2.0 * pi * real'(m - quarter) / real'(1 << log_n);
            tw.re = tf_real_to_f32(-$sin(th));
            tw.im = tf_real_to_f32(-$cos(th));
        end
        return tw;
    endfunction

endpackage

// File: rtl/tf_provider_rom.sv
// Single-port synchronous-read twiddle ROM holding W_N^0 .. W_N^(N/2-1) as {re, im}.
// Contents are evaluated at elaboration so every instance is self-contained.
module tf_rom
    import tf_provider_pkg::*;
#(
    parameter int unsigned addr_len = tf_log_n - 1,
    parameter int unsigned log_n    = tf_log_n
) (
    input  logic                   clk,
    input  logic                   ena,
    input  logic [addr_len-1:0]    addra,
    output logic [tf_word_len-1:0] douta
);

    localparam int unsigned depth = 1 << addr_len;

    logic [tf_word_len-1:0] rom_tbl [depth];

    for (genvar m = 0; m < depth; m++) begin : g_rom
        localparam tf_word_t tw_word = tf_twiddle(m, log_n);
        assign rom_tbl[m] = tw_word;
    end

    // Registered read; no reset so the array maps onto block ROM.
    always_ff @(posedge clk) begin
        if (ena) begin
            douta <= rom_tbl[addra];
        end
    end

endmodule

// File: rtl/tf_provider.sv
// Twiddle-factor provider for one radix-2 DIF stage: counts butterflies, strides into the
// shared half-circle ROM according to the latched stage, and optionally conjugates (IFFT).
module tf_provider
    import tf_provider_pkg::*;
#(
    parameter int unsigned float_len   = tf_float_len,
    parameter int unsigned log_n       = tf_log_n,
    parameter int unsigned tf_addr_len = log_n - 1,
    parameter int unsigned stage_len   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic [stage_len-1:0]   stage,
    input  logic                   inverse,
    input  logic                   en,
    output logic [2*float_len-1:0] data_out,
    output logic                   data_out_valid,
    output logic                   frame_done,
    output logic                   stage_err
);

    localparam int unsigned          cnt_len   = log_n - 1;
    localparam logic [cnt_len-1:0]   cnt_last  = cnt_len'(tf_half_n(log_n) - 1);
    localparam logic [stage_len-1:0] stage_max = stage_len'(log_n);
    localparam int unsigned          im_sign   = tf_sign_bit(float_len);

    logic [cnt_len-1:0]     cnt_q, cnt_d, cnt_cur;
    logic [stage_len-1:0]   stage_q, stage_d, stage_in, stage_cur, shamt;
    logic                   stage_bad;
    logic                   inv_q, inv_d, inv_cur;
    logic                   err_q, err_d;
    logic [tf_addr_len-1:0] span_mask, addr;
    logic                   rd_valid_q, rd_done_q, rd_inv_q;
    logic                   out_valid_q, out_done_q;
    logic [2*float_len-1:0] rom_data, conj_word, out_q;

    // Clamp the requested stage into 1..log_n and flag anything that needed clamping.
    always_comb begin
        stage_in  = stage;
        stage_bad = 1'b0;
        if (stage == '0) begin
            stage_in  = stage_len'(1);
            stage_bad = 1'b1;
        end else if (stage > stage_max) begin
            stage_in  = stage_max;
            stage_bad = 1'b1;
        end
    end

    // A frame_start takes effect on the fetch in the same cycle, so select the fresh values.
    always_comb begin
        cnt_cur   = frame_start ? '0 : cnt_q;
        stage_cur = frame_start ? stage_in : stage_q;
        inv_cur   = frame_start ? inverse : inv_q;
        cnt_d     = en ? cnt_cur + cnt_len'(1) : cnt_cur;
        stage_d   = stage_cur;
        inv_d     = inv_cur;
        err_d     = frame_start ? stage_bad : err_q;
        // addr = (c mod N/2^s) << (s-1)
        shamt     = stage_cur - stage_len'(1);
        span_mask = {tf_addr_len{1'b1}} >> shamt;
        addr      = (tf_addr_len'(cnt_cur) & span_mask) << shamt;
    end

    // Butterfly counter and per-frame stage/mode latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            stage_q <= stage_len'(1);
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            err_q   <= err_d;
        end
    end

    tf_rom #(
        .addr_len (tf_addr_len),
        .log_n    (log_n)
    ) u_rom (
        .clk   (clk),
        .ena   (en),
        .addra (addr),
        .douta (rom_data)
    );

    // Conjugation only flips the sign of the imaginary component.
    always_comb begin
        conj_word          = rom_data;
        conj_word[im_sign] = rom_data[im_sign] ^ rd_inv_q;
    end

    // Valid/done/mode travel alongside the ROM read, then the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q  <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_inv_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_done_q  <= 1'b0;
            out_q       <= '0;
        end else begin
            rd_valid_q  <= en;
            rd_done_q   <= en && (cnt_cur == cnt_last);
            if (en) begin
                rd_inv_q <= inv_cur;
            end
            out_valid_q <= rd_valid_q;
            out_done_q  <= rd_done_q;
            if (rd_valid_q) begin
                out_q <= conj_word;
            end
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = out_valid_q;
    assign frame_done     = out_done_q;
    assign stage_err      = err_q;

endmodule
